// File: rtl/mips_top.sv
// mips_top: single-cycle 32-bit MIPS subset processor with a fixed program.
//
// Ports:
//   clk        system clock; PC, register file and data RAM update on its rising edge
//   rst        asynchronous active-low reset; PC and all registers go to zero
//   writedata  rt register value of the current instruction (store data)
//   dataadr    ALU result; byte address of the data RAM for lw/sw
//   memwrite   high while the current instruction is sw
//
// Supported: add, sub, and, or, slt, lw, sw, beq, addi, j. Every other
// encoding (including the all-zero sll word) retires as a NOP with PC+4.
module mips_top #(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] writedata,
   output logic [31:0] dataadr,
   output logic        memwrite
);

   localparam int DAW      = $clog2(DMEM_WORDS);
   localparam int PROG_LEN = 18;

   localparam logic [31:0] PROG [PROG_LEN] = '{
      32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025,
      32'h00642824, 32'h00a42820, 32'h10a7000a, 32'h0064202a,
      32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
      32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011,
      32'h20020001, 32'hac020054
   };

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_t;

   logic [31:0] pc, pcplus4, pcbranch, pcnext;
   logic [31:0] romword, instr;
   logic [29:0] wordidx;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, writereg;
   logic [31:0] signimm, srca, rtval, srcb, aluresult, readdata, result;
   logic        zero;
   logic        regwrite, regdst, alusrc, branch, memwr, memtoreg, jump;
   alu_t        aluctl;

   logic [31:0] rf   [32];
   logic [31:0] dmem [DMEM_WORDS];

   // Instruction fetch. Any PC past the stored program, including PCs that
   // walk off the end of the ROM, reads as zero so the processor idles on
   // NOPs instead of wrapping back into the program.
   assign wordidx = pc[31:2];
   always_comb begin
      romword = '0;
      if (wordidx < 30'(IMEM_WORDS) && wordidx < 30'(PROG_LEN))
         romword = PROG[wordidx[4:0]];
   end
   assign instr = romword;

   assign op      = instr[31:26];
   assign rs      = instr[25:21];
   assign rt      = instr[20:16];
   assign rd      = instr[15:11];
   assign funct   = instr[5:0];
   assign signimm = {{16{instr[15]}}, instr[15:0]};

   // Main and ALU decode folded together. An R-type with an unknown funct
   // drops regwrite so it behaves as a NOP like any unknown opcode.
   always_comb begin
      regwrite = 1'b0;
      regdst   = 1'b0;
      alusrc   = 1'b0;
      branch   = 1'b0;
      memwr    = 1'b0;
      memtoreg = 1'b0;
      jump     = 1'b0;
      aluctl   = ALU_ADD;
      case (op)
         6'h00: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            case (funct)
               6'h20:   aluctl = ALU_ADD;
               6'h22:   aluctl = ALU_SUB;
               6'h24:   aluctl = ALU_AND;
               6'h25:   aluctl = ALU_OR;
               6'h2A:   aluctl = ALU_SLT;
               default: regwrite = 1'b0;
            endcase
         end
         6'h23: begin
            regwrite = 1'b1;
            alusrc   = 1'b1;
            memtoreg = 1'b1;
         end
         6'h2B: begin
            alusrc = 1'b1;
            memwr  = 1'b1;
         end
         6'h04: begin
            branch = 1'b1;
            aluctl = ALU_SUB;
         end
         6'h08: begin
            regwrite = 1'b1;
            alusrc   = 1'b1;
         end
         6'h02:   jump = 1'b1;
         default: ;
      endcase
   end

   // Register reads; $0 is hardwired to zero.
   assign srca  = (rs == 5'd0) ? 32'd0 : rf[rs];
   assign rtval = (rt == 5'd0) ? 32'd0 : rf[rt];
   assign srcb  = alusrc ? signimm : rtval;

   // ALU: add/sub wrap silently, slt is a signed compare.
   always_comb begin
      aluresult = '0;
      case (aluctl)
         ALU_ADD: aluresult = srca + srcb;
         ALU_SUB: aluresult = srca - srcb;
         ALU_AND: aluresult = srca & srcb;
         ALU_OR:  aluresult = srca | srcb;
         ALU_SLT: aluresult = {31'd0, $signed(srca) < $signed(srcb)};
         default: aluresult = '0;
      endcase
   end
   assign zero = (aluresult == 32'd0);

   assign readdata = dmem[dataadr[DAW+1:2]];
   assign result   = memtoreg ? readdata : aluresult;
   assign writereg = regdst ? rd : rt;

   // Next PC selection: jump beats branch, branch only when rs == rt.
   assign pcplus4  = pc + 32'd4;
   assign pcbranch = pcplus4 + {signimm[29:0], 2'b00};
   always_comb begin
      pcnext = pcplus4;
      if (jump)
         pcnext = {pcplus4[31:28], instr[25:0], 2'b00};
      else if (branch && zero)
         pcnext = pcbranch;
   end

   // Program counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pc <= '0;
      else
         pc <= pcnext;
   end

   // Register file write port; all registers clear on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= '0;
      end else if (regwrite && writereg != 5'd0) begin
         rf[writereg] <= result;
      end
   end

   // Data RAM keeps its contents through reset.
   always_ff @(posedge clk) begin
      if (memwrite)
         dmem[dataadr[DAW+1:2]] <= writedata;
   end

   assign writedata = rtval;
   assign dataadr   = aluresult;
   assign memwrite  = memwr;

endmodule

// File: tb/tb_mips_top.sv
// tb_mips_top: self-checking bench for mips_top. An instruction-level
// reference model executes the same program one instruction per clock and
// predicts PC, store activity and register contents.
module tb_mips_top;

   logic        clk;
   logic        rst;
   logic [31:0] writedata;
   logic [31:0] dataadr;
   logic        memwrite;

   int checkCount;
   int passCount;

   logic [31:0] forceWord;
   logic [31:0] stAdr  [$];
   logic [31:0] stData [$];

   localparam logic [31:0] PROG [18] = '{
      32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025,
      32'h00642824, 32'h00a42820, 32'h10a7000a, 32'h0064202a,
      32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
      32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011,
      32'h20020001, 32'hac020054
   };

   logic [31:0] mRegs [32];
   logic [31:0] mMem  [64];
   logic [31:0] mPc;

   typedef struct {
      logic        mw;
      logic        adrValid;
      logic [31:0] adr;
      logic [31:0] wd;
   } exp_t;

   mips_top #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
      .clk(clk),
      .rst(rst),
      .writedata(writedata),
      .dataadr(dataadr),
      .memwrite(memwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model instruction memory: the program, zero everywhere else.
   function automatic logic [31:0] model_fetch(input logic [31:0] pc);
      if (pc < 32'd72)
         return PROG[pc[6:2]];
      return 32'h0;
   endfunction

   task automatic model_reset();
      mPc = 32'h0;
      for (int i = 0; i < 32; i++)
         mRegs[i] = 32'h0;
   endtask

   // Executes one instruction on the model state and returns what the
   // processor should show on its store port while that instruction is current.
   function automatic exp_t model_exec(input logic [31:0] ins);
      exp_t        e;
      logic [31:0] a, b, imm, addr, res, pc4, nxt;
      logic        wr;
      logic [4:0]  dst;
      a    = mRegs[ins[25:21]];
      b    = mRegs[ins[20:16]];
      imm  = {{16{ins[15]}}, ins[15:0]};
      pc4  = mPc + 32'd4;
      nxt  = pc4;
      wr   = 1'b0;
      dst  = ins[20:16];
      res  = 32'h0;
      addr = a + imm;
      e.mw = 1'b0;
      e.adrValid = 1'b0;
      e.adr = 32'h0;
      e.wd  = b;
      case (ins[31:26])
         6'h00: begin
            dst = ins[15:11];
            wr  = 1'b1;
            case (ins[5:0])
               6'h20:   res = a + b;
               6'h22:   res = a - b;
               6'h24:   res = a & b;
               6'h25:   res = a | b;
               6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: wr = 1'b0;
            endcase
            e.adrValid = wr;
            e.adr = res;
         end
         6'h23: begin
            wr = 1'b1;
            res = mMem[addr[7:2]];
            e.adrValid = 1'b1;
            e.adr = addr;
         end
         6'h2B: begin
            mMem[addr[7:2]] = b;
            e.mw = 1'b1;
            e.adrValid = 1'b1;
            e.adr = addr;
         end
         6'h04: if (a == b) nxt = pc4 + (imm << 2);
         6'h08: begin
            wr = 1'b1;
            res = addr;
            e.adrValid = 1'b1;
            e.adr = addr;
         end
         6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
         default: ;
      endcase
      if (wr && dst != 5'd0)
         mRegs[dst] = res;
      mPc = nxt;
      return e;
   endfunction

   // Called in the low clock phase. Samples the outputs, advances the model,
   // lets one rising edge retire the instruction, returns in the next low phase.
   task automatic do_cycle(input logic doForce, output exp_t e, output logic gmw,
                           output logic [31:0] gadr, output logic [31:0] gwd,
                           output logic [31:0] expPc, output logic [31:0] gotPc);
      if (doForce) begin
         force dut.instr = forceWord;
         #1;
      end
      gmw  = memwrite;
      gadr = dataadr;
      gwd  = writedata;
      e = model_exec(doForce ? forceWord : model_fetch(mPc));
      expPc = mPc;
      @(posedge clk);
      #1;
      gotPc = dut.pc;
      if (doForce) release dut.instr;
      @(negedge clk);
      #1;
   endtask

   task automatic reset_and_release();
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         checkCount++;
         if (memwrite !== 1'b0) $display("[TB] FAIL reset_memwrite cyc=%0d got=%0b exp=0", i, memwrite);
         else passCount++;
         checkCount++;
         if (dataadr !== 32'd5) $display("[TB] FAIL reset_dataadr cyc=%0d got=%0d exp=5", i, dataadr);
         else passCount++;
         checkCount++;
         if (writedata !== 32'd0) $display("[TB] FAIL reset_writedata cyc=%0d got=%0d exp=0", i, writedata);
         else passCount++;
      end
      @(negedge clk);
      #1;
      rst = 1'b1;
      checkCount++;
      if (dut.pc !== 32'h0) $display("[TB] FAIL reset_pc got=%h exp=0", dut.pc);
      else passCount++;
   endtask

   task automatic test_program();
      exp_t e;
      logic gmw;
      logic [31:0] gadr, gwd, ePc, gPc;
      stAdr.delete();
      stData.delete();
      for (int i = 0; i < 100; i++) begin
         do_cycle(1'b0, e, gmw, gadr, gwd, ePc, gPc);
         checkCount++;
         if (gmw !== e.mw) $display("[TB] FAIL prog_memwrite cyc=%0d got=%0b exp=%0b", i, gmw, e.mw);
         else passCount++;
         if (e.adrValid) begin
            checkCount++;
            if (gadr !== e.adr) $display("[TB] FAIL prog_dataadr cyc=%0d got=%h exp=%h", i, gadr, e.adr);
            else passCount++;
         end
         if (e.mw) begin
            checkCount++;
            if (gwd !== e.wd) $display("[TB] FAIL prog_writedata cyc=%0d got=%h exp=%h", i, gwd, e.wd);
            else passCount++;
         end
         if (gmw === 1'b1) begin
            stAdr.push_back(gadr);
            stData.push_back(gwd);
         end
         checkCount++;
         if (gPc !== ePc) $display("[TB] FAIL prog_pc cyc=%0d got=%h exp=%h", i, gPc, ePc);
         else passCount++;
         if (i == 2) begin
            checkCount++;
            if (dut.rf[7] !== 32'd3) $display("[TB] FAIL reg7_checkpoint got=%0d exp=3", dut.rf[7]);
            else passCount++;
         end
         if (i == 6) begin
            checkCount++;
            if (gPc !== 32'h1c) $display("[TB] FAIL beq_not_taken got=%h exp=1c", gPc);
            else passCount++;
         end
      end
      checkCount++;
      if (stAdr.size() != 2) $display("[TB] FAIL store_count got=%0d exp=2", stAdr.size());
      else passCount++;
      if (stAdr.size() >= 2) begin
         checkCount++;
         if (stAdr[0] !== 32'd80 || stData[0] !== 32'd7)
            $display("[TB] FAIL store0 got=(%0d,%0d) exp=(80,7)", stAdr[0], stData[0]);
         else passCount++;
         checkCount++;
         if (stAdr[1] !== 32'd84 || stData[1] !== 32'd7)
            $display("[TB] FAIL store1 got=(%0d,%0d) exp=(84,7)", stAdr[1], stData[1]);
         else passCount++;
      end
      checkCount++;
      if (dut.dmem[20] !== 32'd7) $display("[TB] FAIL dmem_word20 got=%0d exp=7", dut.dmem[20]);
      else passCount++;
      checkCount++;
      if (dut.rf[2] !== 32'd7) $display("[TB] FAIL lw_result_reg2 got=%0d exp=7", dut.rf[2]);
      else passCount++;
   endtask

   task automatic test_midrun_reset(input int atCycle, input int holdCycles);
      exp_t e;
      logic gmw;
      logic [31:0] gadr, gwd, ePc, gPc;
      int bad;
      reset_and_release();
      for (int i = 0; i < atCycle; i++) begin
         do_cycle(1'b0, e, gmw, gadr, gwd, ePc, gPc);
         checkCount++;
         if (gmw !== e.mw || gPc !== ePc)
            $display("[TB] FAIL pre_reset_step cyc=%0d got=(%0b,%h) exp=(%0b,%h)", i, gmw, gPc, e.mw, ePc);
         else passCount++;
      end
      #2;
      rst = 1'b0;
      #1;
      checkCount++;
      if (dut.pc !== 32'h0) $display("[TB] FAIL async_reset_pc at=%0d got=%h exp=0", atCycle, dut.pc);
      else passCount++;
      bad = 0;
      for (int r = 0; r < 32; r++)
         if (dut.rf[r] !== 32'h0) bad++;
      checkCount++;
      if (bad != 0) $display("[TB] FAIL async_reset_regs nonzero=%0d exp=0", bad);
      else passCount++;
      model_reset();
      repeat (holdCycles) @(negedge clk);
      #1;
      rst = 1'b1;
      stAdr.delete();
      stData.delete();
      for (int i = 0; i < 20; i++) begin
         do_cycle(1'b0, e, gmw, gadr, gwd, ePc, gPc);
         checkCount++;
         if (gmw !== e.mw || gPc !== ePc)
            $display("[TB] FAIL rerun_step cyc=%0d got=(%0b,%h) exp=(%0b,%h)", i, gmw, gPc, e.mw, ePc);
         else passCount++;
         if (gmw === 1'b1) begin
            stAdr.push_back(gadr);
            stData.push_back(gwd);
         end
      end
      checkCount++;
      if (stAdr.size() != 2) $display("[TB] FAIL rerun_store_count got=%0d exp=2", stAdr.size());
      else passCount++;
      if (stAdr.size() >= 2) begin
         checkCount++;
         if (stAdr[0] !== 32'd80 || stData[0] !== 32'd7 || stAdr[1] !== 32'd84 || stData[1] !== 32'd7)
            $display("[TB] FAIL rerun_trace got=(%0d,%0d)(%0d,%0d) exp=(80,7)(84,7)",
                     stAdr[0], stData[0], stAdr[1], stData[1]);
         else passCount++;
      end
   endtask

   task automatic test_unsupported(input int iterations);
      exp_t e;
      logic gmw;
      logic [31:0] gadr, gwd, ePc, gPc, tmp;
      logic [5:0] op;
      int slot, bad;
      for (int n = 0; n < iterations; n++) begin
         reset_and_release();
         slot = $urandom_range(0, 15);
         do begin
            op = 6'($urandom_range(0, 63));
         end while (op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B});
         tmp = $urandom();
         forceWord = {op, tmp[25:0]};
         for (int i = 0; i < 30; i++) begin
            do_cycle(i == slot, e, gmw, gadr, gwd, ePc, gPc);
            checkCount++;
            if (gmw !== e.mw) $display("[TB] FAIL nop_run_memwrite cyc=%0d got=%0b exp=%0b", i, gmw, e.mw);
            else passCount++;
            checkCount++;
            if (gPc !== ePc) $display("[TB] FAIL nop_run_pc cyc=%0d got=%h exp=%h", i, gPc, ePc);
            else passCount++;
            if (i == slot) begin
               bad = 0;
               for (int r = 0; r < 32; r++)
                  if (dut.rf[r] !== mRegs[r]) bad++;
               checkCount++;
               if (bad != 0) $display("[TB] FAIL nop_regs word=%h differing=%0d exp=0", forceWord, bad);
               else passCount++;
            end
         end
      end
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst        = 1'b0;
      forceWord  = 32'h0;
      for (int i = 0; i < 64; i++)
         mMem[i] = 32'h0;
      test_reset();
      test_program();
      test_midrun_reset(8, 2);
      test_midrun_reset($urandom_range(1, 16), $urandom_range(1, 4));
      test_unsupported(3);
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mips_top.md
Name: mips_top

Overview:
- Self-contained single-cycle 32-bit MIPS subset processor: PC, register file, ALU, main/ALU decoders, fixed instruction ROM, word data RAM.
- Top of the processor test system.
- Exposes the data-memory write port (address, data, enable) so a bench can watch stores.
- The built-in program ends by storing 7 to byte address 84.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in words.
- DMEM_WORDS, 64, data RAM depth in words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- writedata  output  32  store data (register rt value) of the current instruction.
- dataadr  output  32  ALU result; the data-memory byte address for lw/sw.
- memwrite  output  1  high while the current instruction is sw.

Behaviour:
- Reset: rst=0 forces PC=0 immediately (asynchronous) and clears all 32 registers. The data RAM is not cleared.
- Outputs under reset are purely combinational from instruction 0 (addi): memwrite=0, dataadr=5, writedata=0.
- Single-cycle: one instruction retires per rising clk edge after rst=1. Outputs are combinational from the current PC/instruction and are valid before the next rising edge.
- Supported instructions (anything else behaves as a NOP, PC+4):
  - R-type (op 0): add (funct 20h), sub (22h), and (24h), or (25h), slt (2Ah).
  - lw (23h), sw (2Bh), beq (04h), addi (08h), j (02h).
- ALU: 32-bit; add/sub wrap modulo 2^32 with no overflow trap. slt is a signed compare giving 1/0. The zero flag is used by beq.
- Immediates: sign-extended 16 bits.
- Branch: beq target = PC+4 + (signimm<<2), taken when rs==rt.
- Jump: j target = {PC+4[31:28], instr[25:0], 2'b00}.
- Register file: 32x32, two combinational read ports, one write port on the rising edge.
  - $0 always reads 0; writes to it are ignored.
  - R-type writes rd; lw/addi write rt.
  - lw writes the memory word; all other writers write the ALU result.
- Data RAM: word-indexed by dataadr[7:2]. Combinational read; synchronous write on the rising edge when memwrite=1. The low two address bits are ignored.
- Instruction ROM: indexed by PC[7:2]. Words beyond the program read 0 (sll $0 = NOP).
- ROM contents, hex, address 0 upward:
  20020005 2003000c 2067fff7 00e22025 00642824 00a42820 10a7000a 0064202a 10800001 20050000 00e2202a 00853820 00e23822 ac670044 8c020050 08000011 20020001 ac020054.
- Required store trace after reset release: exactly two memwrite cycles.
  - First: dataadr=80, writedata=7.
  - Second: dataadr=84, writedata=7.
- After the last instruction, PC runs into NOPs. The 84 store occurs once and is never repeated unless reset is reasserted.
- Reset mid-run: PC returns to 0 asynchronously, the registers clear, and the program restarts on release. Data RAM keeps its old values.

Test Plan:
- Hold rst=0 for 10 cycles, then set rst=1 -> memwrite stays 0 while in reset; program starts at PC=0 on the first edge after release.
- Run 20 cycles, checking memwrite on each falling edge -> the only writes are (80,7) then (84,7); any other write address is a failure.
- Register checkpoint after instruction 3 (addi $7,$3,-9) -> $7=3; after instruction 6, beq not taken ($5=11 vs $7=3).
- After 18 instructions, read data RAM word 20 -> 7; lw $2,80 returns 7; the addi at 0x40 is skipped by j.
- Assert rst=0 mid-program at cycle 8 for 2 cycles, then release -> the full trace repeats, ending with (84,7) again.
- Unsupported opcode word forced into the ROM slot -> acts as a NOP: no register or memory write, PC+4.
